// File: rtl/data_arb_pkg.sv
// Shared types and widths for the cache data-array arbiter.
package data_arb_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 256;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE     = 1'b0,
        LOCKED_B = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [NUM_WMASKS-1:0] wmask;
        logic [DATA_WIDTH-1:0] wdata;
    } port_req_t;

endpackage

// File: rtl/data_arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module data_arb_sat_counter #(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] SAT_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // count up to SAT_VAL and hold there until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != SAT_VAL)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/data_array_arbiter.sv
// Arbiter/sequencer for the single-port 32x256 cache data array.
// Port A: CPU hit path (byte-masked). Port B: fill/evict path (full line, lock).
// Optional build macro DATA_ARB_STATS_EN adds grant/stall statistics counters.
//
// state    | meaning
// IDLE     | normal arbitration: aged A, then B, then A
// LOCKED_B | port B owns the array; only B is granted, aging cannot preempt
module data_array_arbiter
    import data_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [NUM_WMASKS-1:0] wmask_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    input  logic                  lock_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
`ifdef DATA_ARB_STATS_EN
    input  logic                  stat_clr,
    output logic [31:0]           stat_gnt_a,
    output logic [31:0]           stat_gnt_b,
    output logic [31:0]           stat_stall_a,
`endif
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam int             WAIT_W     = 4;
    localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

    arb_state_t        state, state_nxt;
    port_req_t         a_s, b_s;
    logic [WAIT_W-1:0] wait_cnt;

    assign a_s = '{req: req_a, we: we_a, addr: addr_a, wmask: wmask_a, wdata: wdata_a};
    assign b_s = '{req: req_b, we: we_b, addr: addr_b, wmask: '1, wdata: wdata_b};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // a locked B access keeps ownership; anything else returns to IDLE
    always_comb begin
        state_nxt = IDLE;
        if (gnt_b && lock_b) state_nxt = LOCKED_B;
    end

    // grant decode; held low while reset is asserted so the array is released at once
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_n) begin
            if (state == LOCKED_B)                   gnt_b = b_s.req;
            else if (a_s.req && wait_cnt == MAX_WAIT_V) gnt_a = 1'b1;
            else if (b_s.req)                        gnt_b = 1'b1;
            else if (a_s.req)                        gnt_a = 1'b1;
        end
    end

    // array pins steered from the winner
    always_comb begin
        sram_csb   = !(gnt_a | gnt_b);
        sram_web   = gnt_a ? !a_s.we    : !b_s.we;
        sram_addr  = gnt_a ? a_s.addr   : b_s.addr;
        sram_wmask = gnt_a ? a_s.wmask  : b_s.wmask;
        sram_din   = gnt_a ? a_s.wdata  : b_s.wdata;
    end

    // read-valid follows an accepted read by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= gnt_a & ~a_s.we;
            rvalid_b <= gnt_b & ~b_s.we;
        end
    end

    assign rdata_a = sram_dout;
    assign rdata_b = sram_dout;

    data_arb_sat_counter #(.WIDTH(WAIT_W), .SAT_VAL(MAX_WAIT_V)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (req_a & ~gnt_a),
        .clr   (~req_a | gnt_a),
        .count (wait_cnt)
    );

`ifdef DATA_ARB_STATS_EN
    data_arb_sat_counter #(.WIDTH(32)) u_stat_gnt_a (
        .clk(clk), .rst_n(rst_n), .inc(gnt_a), .clr(stat_clr), .count(stat_gnt_a)
    );
    data_arb_sat_counter #(.WIDTH(32)) u_stat_gnt_b (
        .clk(clk), .rst_n(rst_n), .inc(gnt_b), .clr(stat_clr), .count(stat_gnt_b)
    );
    data_arb_sat_counter #(.WIDTH(32)) u_stat_stall_a (
        .clk(clk), .rst_n(rst_n), .inc(req_a & ~gnt_a), .clr(stat_clr), .count(stat_stall_a)
    );
`endif

endmodule
